serial_shifter: RTL and testbench

//  Multi-cycle shift unit: same operation set as the single-cycle barrel shifter,
//  one bit position per clock instead of a log2 mux tree.

---
 rtl/serial_shifter.sv | 133 +++++++++++++
 tb/tb_serial_shifter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_shifter.sv
// -----------------------------------------------------------------------------
// serial_shifter
//   Multi-cycle shift unit offering the same operations as the single-cycle
//   barrel shifter (SLL, SRL, SRA, ROR), but moving one bit position per clock.
//   A request (a, amt, mode) is taken over a valid/ready channel, the operand is
//   shifted in place for amt cycles, and the result is returned over a second
//   valid/ready channel. Only one operation is in flight at a time.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req_valid  in   1      request present on a/amt/mode
//   req_ready  out  1      unit idle and able to accept a request
//   a          in   width  operand
//   amt        in   v      shift amount, 0..width-1
//   mode       in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   rsp_valid  out  1      y holds a completed result
//   rsp_ready  in   1      consumer takes the result
//   y          out  width  result
//   busy       out  1      operation in progress or result waiting
// -----------------------------------------------------------------------------
module serial_shifter #(
    parameter  int width = 16,
    localparam int v     = $clog2(width)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [width-1:0] a,
    input  logic [v-1:0]     amt,
    input  logic [1:0]       mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [width-1:0] y,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_r;
    logic [width-1:0] y_r;
    logic [v-1:0]     count_r;
    logic [1:0]       mode_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic             busy_r;

    // One single-bit step of the selected shift operation.
    function automatic logic [width-1:0] shift_step(
        input logic [width-1:0] val,
        input logic [1:0]       m
    );
        logic [width-1:0] res;
        case (m)
            2'b00:   res = {val[width-2:0], 1'b0};
            2'b01:   res = {1'b0, val[width-1:1]};
            2'b10:   res = {val[width-1], val[width-1:1]};
            2'b11:   res = {val[0], val[width-1:1]};
            default: res = val;
        endcase
        return res;
    endfunction

    // Control FSM and datapath; handshake flags are registered alongside state
    // so they never depend combinationally on the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            y_r         <= '0;
            count_r     <= '0;
            mode_r      <= 2'b00;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        y_r         <= a;
                        count_r     <= amt;
                        mode_r      <= mode;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (amt == '0) begin
                            // Nothing to shift: result is the operand itself.
                            state_r     <= DONE;
                            rsp_valid_r <= 1'b1;
                        end else begin
                            state_r     <= SHIFT;
                            rsp_valid_r <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    y_r     <= shift_step(y_r, mode_r);
                    count_r <= count_r - v'(1);
                    // Last step happens on this edge; result is then final.
                    if (count_r == v'(1)) begin
                        state_r     <= DONE;
                        rsp_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // y is held untouched until the consumer takes it.
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    count_r     <= '0;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign y         = y_r;
    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_serial_shifter.sv
// -----------------------------------------------------------------------------
// tb_serial_shifter
//   Self-checking bench for serial_shifter (width 16). Drives inputs and samples
//   outputs on the falling edge; expected results come from a plain arithmetic
//   reference of the shift operations.
// -----------------------------------------------------------------------------
module tb_serial_shifter;

    localparam int W = 16;
    localparam int V = 4;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] a;
    logic [V-1:0] amt;
    logic [1:0]   mode;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] y;
    logic         busy;

    int checks;
    int errors;

    serial_shifter #(.width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .amt       (amt),
        .mode      (mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .y         (y),
        .busy      (busy)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference shifter in plain arithmetic.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] val, input int n, input logic [1:0] m);
        logic [31:0] u;
        int          s;
        logic [31:0] r;
        u = 32'(val);
        s = int'($signed(val));
        case (m)
            2'b00:   r = u << n;
            2'b01:   r = u >> n;
            2'b10:   r = 32'(s >>> n);
            default: r = (u >> n) | (u << (W - n));
        endcase
        return r[W-1:0];
    endfunction

    // One complete transaction starting from IDLE at a falling edge.
    task automatic run_op(input logic [W-1:0] op_a, input logic [V-1:0] op_amt,
                          input logic [1:0] op_mode, input int hold, input logic [W-1:0] exp_y);
        int cyc;
        check_val("req_ready_idle", 32'(req_ready), 32'd1);
        a         = op_a;
        amt       = op_amt;
        mode      = op_mode;
        req_valid = 1'b1;
        @(negedge clk);
        // Scramble inputs after accept; they must be ignored.
        req_valid = 1'b0;
        a         = W'($urandom);
        amt       = V'($urandom);
        mode      = 2'($urandom);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_val("latency", 32'(cyc), 32'(int'(op_amt) + 1));
        check_val("y", 32'(y), 32'(exp_y));
        check_val("busy_done", 32'(busy), 32'd1);
        check_val("req_ready_done", 32'(req_ready), 32'd0);
        // Back-pressure window with stray request pulses.
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            @(negedge clk);
            check_val("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check_val("hold_y", 32'(y), 32'(exp_y));
            check_val("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("rsp_valid_taken", 32'(rsp_valid), 32'd0);
        check_val("req_ready_after", 32'(req_ready), 32'd1);
        check_val("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        a         = '0;
        amt       = '0;
        mode      = 2'b00;
        repeat (2) @(negedge clk);
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_y", 32'(y), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while shifting aborts immediately, no clock edge needed.
        a = 16'hF0F0; amt = 4'd15; mode = 2'b00; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_req_ready", 32'(req_ready), 32'd1);
        check_val("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("abort_y", 32'(y), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived results.
        run_op(16'hF0F0, 4'd4,  2'b00, 0, 16'h0F00);
        run_op(16'hF0F0, 4'd4,  2'b01, 0, 16'h0F0F);
        run_op(16'hF0F0, 4'd3,  2'b10, 0, 16'hFE1E);
        run_op(16'hF0F0, 4'd4,  2'b11, 0, 16'h0F0F);
        run_op(16'hF0F0, 4'd15, 2'b11, 0, 16'hE1E1);
        for (int m = 0; m < 4; m++) begin
            run_op(16'hF0F0, 4'd0, 2'(m), 0, 16'hF0F0);
        end
        run_op(16'hF0F0, 4'd4, 2'b00, 10, 16'h0F00);
        run_op(16'hF0F0, 4'd0, 2'b10, 10, 16'hF0F0);

        // Full sweep, back to back, random operands against the reference.
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < W; n++) begin
                logic [W-1:0] ra;
                ra = W'($urandom);
                if (n == 5) ra[W-1] = 1'b1;
                run_op(ra, V'(n), 2'(m), (n == 7) ? 3 : 0, ref_shift(ra, n, 2'(m)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
